bmd_256_latency_drain_tx: RTL and testbench
===========================================

# bmd_256_latency_drain_tx

TX-side drain engine for the receive-timestamp FIFO in the BMD 256-bit latency path. Once the RX side asserts `fifo_read_trigger`, this block pops 30-bit timestamps one at a time and converts each to a 32-bit delta word. It packs eight words per 256-bit beat and presents the beats to the TX engine over a valid/ready handshake. Each packet holds at most `BEATS_PER_PKT` beats.

## Interface
Parameters:
- `CNT_W`, 30, timestamp width; must be ≤ 30.
- `WORDS_PER_BEAT`, 8, 32-bit words per 256-bit beat; fixed.
- `BEATS_PER_PKT`, 4, maximum beats per packet.

Ports:
- `clk`  in  1  single clock, 250 MHz; all logic is in this domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `latency_reset_signal`  in  1  synchronous clear; same effect as reset.
- `fifo_read_trigger`  in  1  FIFO drain request from RX.
- `fifo_counter_empty_out`  in  1  FIFO empty, registered (lags the FIFO by 1 cycle).
- `fifo_counter_value_out`  in  CNT_W  FIFO dout; valid 1 cycle after a read.
- `fifo_counter_read_en`  out  1  FIFO pop, single-cycle pulse.
- `tx_data`  out  256  beat payload; word k is on bits [32k+31:32k].
- `tx_valid`  out  1  beat valid.
- `tx_sop`  out  1  first beat of a packet; qualified by `tx_valid`.
- `tx_eop`  out  1  last beat of a packet; qualified by `tx_valid`.
- `tx_ready`  in  1  TX engine accepts the beat.
- `pkt_count`  out  16  packets completed; wraps at 2^16.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, CAPTURE, SEND.
- IDLE → ISSUE when `fifo_read_trigger && !fifo_counter_empty_out`.
- ISSUE: assert `fifo_counter_read_en` for 1 cycle, then go to CAPTURE.
- CAPTURE: latch `fifo_counter_value_out` and compute `delta = (cur − prev) mod 2^CNT_W`.
  - Word layout: bit31 = `first`, bit30 = 0, bits[29:0] = delta zero-extended.
  - Store the word at `word_idx`, then set `prev ← cur` and clear `first`.
  - If `word_idx == 7`: go to SEND.
  - Else if `fifo_read_trigger && !fifo_counter_empty_out`: go to ISSUE.
  - Else if `!fifo_read_trigger && word_idx > 0`: go to SEND (flush).
  - Otherwise go to IDLE and keep the partial beat.
- IDLE with `word_idx > 0` and `!fifo_read_trigger` → SEND (flush).
- SEND drives `tx_valid`.
  - Unfilled words are 32'h0.
  - `tx_sop = (beat_idx == 0)`.
  - `tx_eop = (beat_idx == BEATS_PER_PKT−1) || fifo_counter_empty_out || !fifo_read_trigger`, sampled on SEND entry and held for the beat.
- A beat transfers when `tx_valid && tx_ready`. On transfer:
  - Clear `word_idx` and the word buffer.
  - If eop: set `beat_idx ← 0` and increment `pkt_count`; else increment `beat_idx`.
  - Go to IDLE.
- `prev` resets to 0 and `first` resets to 1. The first word after any reset therefore carries the raw timestamp with bit31 set.
- No read is issued while in SEND; backpressure stalls the FIFO drain.

## Timing
- Reset values: all outputs 0; internal state = IDLE; `word_idx = beat_idx = 0`; `prev = 0`; `first = 1`.
- Read loop: `read_en` at cycle t, capture at t+1, next `read_en` no earlier than t+2.
  - At t+2, `fifo_counter_empty_out` already reflects the pop at t, so the block never over-reads.
  - Sustained rate: 1 entry per 2 cycles.
- CAPTURE → SEND: `tx_valid` rises on the next cycle.
- `tx_data`, `tx_sop` and `tx_eop` are stable while `tx_valid && !tx_ready`. `tx_valid` drops on the cycle after acceptance.
- `latency_reset_signal` has the same effect as reset on the next edge, from any state.
  - A beat in flight is abandoned: `tx_valid` goes to 0 without an eop.
  - `pkt_count` clears to 0.
  - `fifo_counter_read_en` is 0 in that cycle.
- Delta wrap-around is modulo 2^CNT_W. No saturation.

## Test plan
- Reset: hold `rst_n` low, drive random inputs → every output is 0; after release, `busy` = 0 until the trigger asserts.
- FIFO holds 100,110,…,170; trigger=1; `tx_ready`=1 → `read_en` pulses on alternate cycles, 8 total. One beat with word0 = 0x80000064, words1–7 = 0x0000000A, sop = eop = 1. `pkt_count` = 1.
- 32 entries, step 5, trigger=1 → 4 beats; sop on beat 0 only, eop on beat 3 only. `pkt_count` = 1; 32 reads, no read while `tx_valid` = 1.
- Wrap-around: 0x3FFFFFF0 then 0x00000010 → word1 = 0x00000020.
- Partial flush: 3 entries, trigger falls after they drain → one beat, words0–2 = data, words3–7 = 0, sop = eop = 1.
- Backpressure: hold `tx_ready` = 0 for 10 cycles mid-packet → payload held, `read_en` = 0 throughout. Assert `latency_reset_signal` during the stall → `tx_valid` = 0 next cycle and `pkt_count` = 0. The next emitted word0 has bit31 = 1.

Source files
------------

// File: rtl/bmd_256_latency_drain_tx_if.sv
// TX beat channel from the latency drain engine to the TX engine.
// Payload plus framing, qualified by a valid/ready handshake.
interface bmd_256_latency_drain_tx_if;
    logic [255:0] tx_data;
    logic         tx_valid;
    logic         tx_sop;
    logic         tx_eop;
    logic         tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_sop,
        output tx_eop,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_sop,
        input  tx_eop,
        output tx_ready
    );
endinterface

// File: rtl/bmd_256_latency_drain_tx.sv
// Drains the RX timestamp FIFO, converts entries to delta words and
// packs eight words per 256-bit beat for the TX engine.
module bmd_256_latency_drain_tx #(
    parameter int CNT_W          = 30,
    parameter int WORDS_PER_BEAT = 8,
    parameter int BEATS_PER_PKT  = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               latency_reset_signal,
    input  logic                               fifo_read_trigger,
    input  logic                               fifo_counter_empty_out,
    input  logic [CNT_W-1:0]                   fifo_counter_value_out,
    output logic                               fifo_counter_read_en,
    bmd_256_latency_drain_tx_if.master         tx,
    output logic [15:0]                        pkt_count,
    output logic                               busy
);

    localparam int BW = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_PKT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [2:0]                           word_idx_q, word_idx_d;
    logic [BW-1:0]                        beat_idx_q, beat_idx_d;
    logic [CNT_W-1:0]                     prev_q, prev_d;
    logic                                 first_q, first_d;
    logic                                 eop_q, eop_d;
    logic [15:0]                          pkt_cnt_q, pkt_cnt_d;
    logic [WORDS_PER_BEAT-1:0][31:0]      buf_q, buf_d;

    logic                                 can_read;
    logic                                 eop_calc;
    logic [CNT_W-1:0]                     delta;
    logic [29:0]                          delta_ext;
    logic [31:0]                          word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            beat_idx_q <= '0;
            prev_q     <= '0;
            first_q    <= 1'b1;
            eop_q      <= 1'b0;
            pkt_cnt_q  <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            beat_idx_q <= beat_idx_d;
            prev_q     <= prev_d;
            first_q    <= first_d;
            eop_q      <= eop_d;
            pkt_cnt_q  <= pkt_cnt_d;
            buf_q      <= buf_d;
        end
    end

    always_comb begin
        can_read  = fifo_read_trigger && !fifo_counter_empty_out;
        eop_calc  = (beat_idx_q == LAST_BEAT) || fifo_counter_empty_out
                    || !fifo_read_trigger;
        delta     = fifo_counter_value_out - prev_q;
        delta_ext = '0;
        delta_ext[CNT_W-1:0] = delta;
        word      = {first_q, 1'b0, delta_ext};
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        beat_idx_d = beat_idx_q;
        prev_d     = prev_q;
        first_d    = first_q;
        eop_d      = eop_q;
        pkt_cnt_d  = pkt_cnt_q;
        buf_d      = buf_q;

        unique case (state_q)
            IDLE: begin
                if (can_read) begin
                    state_d = ISSUE;
                end else if (word_idx_q != 3'd0 && !fifo_read_trigger) begin
                    state_d = SEND;
                    eop_d   = eop_calc;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                buf_d[word_idx_q] = word;
                word_idx_d        = word_idx_q + 3'd1;
                prev_d            = fifo_counter_value_out;
                first_d           = 1'b0;
                if (word_idx_q == 3'd7) begin
                    state_d = SEND;
                    eop_d   = eop_calc;
                end else if (can_read) begin
                    state_d = ISSUE;
                end else if (!fifo_read_trigger && word_idx_q != 3'd0) begin
                    state_d = SEND;
                    eop_d   = eop_calc;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (tx.tx_ready) begin
                    state_d    = IDLE;
                    buf_d      = '0;
                    word_idx_d = '0;
                    if (eop_q) begin
                        beat_idx_d = '0;
                        pkt_cnt_d  = pkt_cnt_q + 16'd1;
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // synchronous clear overrides every transition, including a stalled beat
        if (latency_reset_signal) begin
            state_d    = IDLE;
            word_idx_d = '0;
            beat_idx_d = '0;
            prev_d     = '0;
            first_d    = 1'b1;
            eop_d      = 1'b0;
            pkt_cnt_d  = '0;
            buf_d      = '0;
        end
    end

    assign fifo_counter_read_en = (state_q == ISSUE) && !latency_reset_signal;
    assign tx.tx_valid          = (state_q == SEND);
    assign tx.tx_sop            = (state_q == SEND) && (beat_idx_q == '0);
    assign tx.tx_eop            = (state_q == SEND) && eop_q;
    assign tx.tx_data           = buf_q;
    assign pkt_count            = pkt_cnt_q;
    assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_bmd_256_latency_drain_tx.sv
// Directed bench for the latency drain engine: FIFO model, beat
// monitor and a table of hand-computed expected beats.
module tb_bmd_256_latency_drain_tx;

    typedef struct {
        logic [255:0] data;
        logic         sop;
        logic         eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lat_rst;
    logic        trig;
    logic        rd_en;
    logic        empty_in;
    logic [29:0] val_in;
    logic [15:0] pkt_count;
    logic        busy;

    logic        rnd_mode = 1'b1;
    logic        rnd_empty;
    logic [29:0] rnd_val;

    logic [29:0] fifo_q[$];
    logic [29:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;

    beat_t       got[$];
    beat_t       exp_tab[9];
    int          rd_cyc[$];
    int          cyc = 0;
    int          overread = 0;
    int          overlap = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    bmd_256_latency_drain_tx_if tx_if ();

    bmd_256_latency_drain_tx dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .latency_reset_signal   (lat_rst),
        .fifo_read_trigger      (trig),
        .fifo_counter_empty_out (empty_in),
        .fifo_counter_value_out (val_in),
        .fifo_counter_read_en   (rd_en),
        .tx                     (tx_if),
        .pkt_count              (pkt_count),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    assign empty_in = rnd_mode ? rnd_empty : fifo_empty;
    assign val_in   = rnd_mode ? rnd_val : fifo_dout;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: dout valid the cycle after a pop, empty updated on the same edge
    always @(posedge clk) begin
        if (rd_en && !rnd_mode) begin
            if (fifo_q.size() == 0) overread++;
            else fifo_dout <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (rst_n && !rnd_mode) begin
            if (rd_en) begin
                rd_cyc.push_back(cyc);
                if (tx_if.tx_valid) overlap++;
            end
            if (tx_if.tx_valid && tx_if.tx_ready)
                got.push_back('{tx_if.tx_data, tx_if.tx_sop, tx_if.tx_eop});
        end
    end

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [255:0] rep(logic [31:0] w0, logic [31:0] w, int n);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[32*k +: 32] = (k == 0) ? w0 : w;
        return r;
    endfunction

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_beats(int n, int budget, string nm);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_timeout"}, 256'(got.size() >= n), 256'(1));
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : main
        int          bad;
        int          k;
        logic [255:0] snap;
        beat_t       g;

        exp_tab[0] = '{rep(32'h8000_0064, 32'h0000_000A, 8), 1'b1, 1'b1};
        exp_tab[1] = '{rep(32'h0000_001E, 32'h0000_0005, 8), 1'b1, 1'b0};
        exp_tab[2] = '{rep(32'h0000_0005, 32'h0000_0005, 8), 1'b0, 1'b0};
        exp_tab[3] = '{rep(32'h0000_0005, 32'h0000_0005, 8), 1'b0, 1'b0};
        exp_tab[4] = '{rep(32'h0000_0005, 32'h0000_0005, 8), 1'b0, 1'b1};
        exp_tab[5] = '{rep(32'h3FFF_FE8D, 32'h0000_0020, 2), 1'b1, 1'b1};
        exp_tab[6] = '{rep(32'h0000_0040, 32'h0000_0010, 3), 1'b1, 1'b1};
        exp_tab[7] = '{rep(32'h0000_0090, 32'h0000_0003, 8), 1'b1, 1'b0};
        exp_tab[8] = '{rep(32'h8000_0130, 32'h0000_0003, 4), 1'b1, 1'b1};

        lat_rst = 1'b0;
        trig = 1'b0;
        tx_if.tx_ready = 1'b0;
        rnd_empty = 1'b1;
        rnd_val = '0;

        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            drive_edge();
            trig = 1'($urandom);
            lat_rst = 1'($urandom);
            tx_if.tx_ready = 1'($urandom);
            rnd_empty = 1'($urandom);
            rnd_val = 30'($urandom);
            @(negedge clk);
            chk("rst_ctl", 256'({rd_en, tx_if.tx_valid, tx_if.tx_sop,
                tx_if.tx_eop, busy, pkt_count}), 256'(0));
            chk("rst_data", tx_if.tx_data, 256'(0));
        end

        drive_edge();
        rnd_mode = 1'b0;
        trig = 1'b0;
        lat_rst = 1'b0;
        tx_if.tx_ready = 1'b1;
        rst_n = 1'b1;
        wait_cycles(3);
        chk("idle_busy", 256'(busy), 256'(0));

        // single full beat, 100..170
        drive_edge();
        rd_cyc.delete();
        for (int i = 0; i < 8; i++) fifo_q.push_back(30'(100 + 10 * i));
        trig = 1'b1;
        wait_beats(1, 100, "t1");
        @(negedge clk);
        chk("t1_valid_drop", 256'(tx_if.tx_valid), 256'(0));
        chk("t1_pkt", 256'(pkt_count), 256'(1));
        chk("t1_reads", 256'(rd_cyc.size()), 256'(8));
        bad = 0;
        for (int i = 1; i < rd_cyc.size(); i++)
            if (rd_cyc[i] - rd_cyc[i-1] != 2) bad++;
        chk("t1_gap", 256'(bad), 256'(0));

        // full packet of four beats, 200..355 step 5
        drive_edge();
        rd_cyc.delete();
        for (int i = 0; i < 32; i++) fifo_q.push_back(30'(200 + 5 * i));
        wait_beats(5, 400, "t2");
        @(negedge clk);
        chk("t2_reads", 256'(rd_cyc.size()), 256'(32));
        chk("t2_pkt", 256'(pkt_count), 256'(2));

        // wrap-around, flushed as a partial beat
        drive_edge();
        fifo_q.push_back(30'h3FFF_FFF0);
        fifo_q.push_back(30'h0000_0010);
        wait_cycles(12);
        drive_edge();
        trig = 1'b0;
        wait_beats(6, 50, "t3");

        // three-entry partial flush
        drive_edge();
        trig = 1'b1;
        fifo_q.push_back(30'h50);
        fifo_q.push_back(30'h60);
        fifo_q.push_back(30'h70);
        wait_cycles(14);
        drive_edge();
        trig = 1'b0;
        wait_beats(7, 50, "t4");
        @(negedge clk);
        chk("t4_pkt", 256'(pkt_count), 256'(4));

        // backpressure mid-packet, then synchronous clear during the stall
        drive_edge();
        trig = 1'b1;
        for (int i = 0; i < 20; i++) fifo_q.push_back(30'(32'h100 + 3 * i));
        wait_beats(8, 100, "t5a");
        drive_edge();
        tx_if.tx_ready = 1'b0;
        k = 0;
        while (!tx_if.tx_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t5_stall_valid", 256'(tx_if.tx_valid), 256'(1));
        chk("t5_stall_data", tx_if.tx_data, rep(32'h3, 32'h3, 8));
        chk("t5_stall_frame", 256'({tx_if.tx_sop, tx_if.tx_eop}), 256'(0));
        snap = tx_if.tx_data;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!tx_if.tx_valid || tx_if.tx_data !== snap || rd_en) bad++;
        end
        chk("t5_hold", 256'(bad), 256'(0));
        drive_edge();
        lat_rst = 1'b1;
        @(negedge clk);
        chk("t5_lrst_rd", 256'(rd_en), 256'(0));
        drive_edge();
        lat_rst = 1'b0;
        tx_if.tx_ready = 1'b1;
        @(negedge clk);
        chk("t5_lrst_valid", 256'(tx_if.tx_valid), 256'(0));
        chk("t5_lrst_pkt", 256'(pkt_count), 256'(0));
        wait_cycles(12);
        drive_edge();
        trig = 1'b0;
        wait_beats(9, 50, "t5b");
        @(negedge clk);
        chk("t5_pkt", 256'(pkt_count), 256'(1));

        chk("overread", 256'(overread), 256'(0));
        chk("rd_while_valid", 256'(overlap), 256'(0));
        chk("n_beats", 256'(got.size()), 256'(9));
        for (int i = 0; i < 9; i++) begin
            g = (i < got.size()) ? got[i] : '{256'(0), 1'bx, 1'bx};
            chk($sformatf("beat%0d_data", i), g.data, exp_tab[i].data);
            chk($sformatf("beat%0d_sop", i), 256'(g.sop), 256'(exp_tab[i].sop));
            chk($sformatf("beat%0d_eop", i), 256'(g.eop), 256'(exp_tab[i].eop));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
